// File: rtl/frame_scanout_pkg.sv
// rtl/frame_scanout_pkg.sv - shared defaults, FSM encoding, flag struct and CRC step for frame_scanout
package frame_scanout_pkg;

    localparam int DEF_PX_WIDTH  = 160;
    localparam int DEF_PX_HEIGHT = 120;
    localparam int DEF_PIX_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pix_flags_t;

    // CRC-16-CCITT (poly 0x1021), one byte, MSB first
    function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/scanout_fifo.sv
// rtl/scanout_fifo.sv - synchronous skid FIFO with occupancy count, head presented combinationally
module scanout_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_en) begin
                rptr <= rptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rptr];
    assign empty   = (count == '0);

endmodule

// File: rtl/frame_scanout.sv
// rtl/frame_scanout.sv - streams one framebuffer frame as a handshaked pixel stream
// Optional FRAME_SCANOUT_CRC_EN adds frame_crc (CRC-16-CCITT over accepted pixels).
module frame_scanout
    import frame_scanout_pkg::*;
#(
    parameter int PX_WIDTH   = DEF_PX_WIDTH,
    parameter int PX_HEIGHT  = DEF_PX_HEIGHT,
    parameter int PIX_W      = DEF_PIX_W,
    parameter int ADDR_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_data,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic [15:0]       frame_cnt
`ifdef FRAME_SCANOUT_CRC_EN
    ,
    output logic [15:0]       frame_crc
`endif
);

    localparam int XW    = $clog2(PX_WIDTH);
    localparam int YW    = $clog2(PX_HEIGHT);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [XW-1:0] X_LAST = XW'(PX_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(PX_HEIGHT - 1);

    scan_state_t state_q, state_d;

    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [ADDR_W-1:0] addr_q;
    logic              last_xy;
    logic              start_accept;
    pix_flags_t        rd_flags;

    logic [RD_LAT-1:0] pipe_valid;
    pix_flags_t [RD_LAT-1:0] pipe_flags;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic [PIX_W+2:0]  fifo_head;
    pix_flags_t        head_flags;
    logic [PIX_W-1:0]  head_data;
    logic              pop;
    logic [CNT_W:0]    credit_used;
    logic              credit_ok;

    assign last_xy      = (x_q == X_LAST) && (y_q == Y_LAST);
    assign rd_flags.sof = (x_q == '0) && (y_q == '0);
    assign rd_flags.eol = (x_q == X_LAST);
    assign rd_flags.eof = last_xy;

    // Reads in flight plus FIFO occupancy, less the entry leaving this cycle,
    // bounds what can land in the FIFO: returning data always has a slot.
    always_comb begin
        credit_used = {1'b0, fifo_count};
        for (int i = 0; i < RD_LAT; i++) begin
            credit_used = credit_used + {{CNT_W{1'b0}}, pipe_valid[i]};
        end
        if (pop) begin
            credit_used = credit_used - (CNT_W+1)'(1);
        end
    end
    assign credit_ok = (credit_used < (CNT_W+1)'(FIFO_DEPTH));

    always_comb begin
        state_d      = state_q;
        mem_rd       = 1'b0;
        done         = 1'b0;
        start_accept = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_d      = ST_SCAN;
                end
            end
            ST_SCAN: begin
                mem_rd = credit_ok;
                if (credit_ok && last_xy) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && head_flags.eof) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            addr_q    <= '0;
            frame_cnt <= '0;
        end else begin
            state_q <= state_d;
            // Counters wrap to zero on the final read, so they rest at 0 between frames
            if (mem_rd) begin
                x_q    <= (x_q == X_LAST) ? '0 : x_q + XW'(1);
                addr_q <= last_xy ? '0 : addr_q + ADDR_W'(1);
                if (x_q == X_LAST) begin
                    y_q <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
                end
            end
            if (done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pipe_valid <= '0;
            pipe_flags <= '0;
        end else begin
            pipe_valid[0] <= mem_rd;
            pipe_flags[0] <= rd_flags;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_flags[i] <= pipe_flags[i-1];
            end
        end
    end

    scanout_fifo #(
        .WIDTH (PIX_W + 3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clr_n   (clr_n),
        .wr_en   (pipe_valid[RD_LAT-1]),
        .wr_data ({pipe_flags[RD_LAT-1], mem_data}),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign {head_flags, head_data} = fifo_head;
    assign pix_valid = !fifo_empty;
    assign pix_data  = pix_valid ? head_data : '0;
    assign pix_sof   = pix_valid & head_flags.sof;
    assign pix_eol   = pix_valid & head_flags.eol;
    assign pix_eof   = pix_valid & head_flags.eof;
    assign pop       = pix_valid & pix_ready;
    assign busy      = (state_q != ST_IDLE);
    assign mem_addr  = addr_q;

`ifdef FRAME_SCANOUT_CRC_EN
    logic [15:0] crc_acc;
    logic [15:0] crc_next;

    assign crc_next = crc16_ccitt_byte(crc_acc, 8'(pix_data));

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            crc_acc   <= 16'hFFFF;
            frame_crc <= 16'hFFFF;
        end else begin
            if (start_accept) begin
                crc_acc <= 16'hFFFF;
            end else if (pop) begin
                crc_acc <= crc_next;
            end
            if (done) begin
                frame_crc <= crc_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_frame_scanout.sv
// tb/tb_frame_scanout.sv - directed bench for frame_scanout, 4x3 frame at read latency 1 and 3
module tb_frame_scanout;

    logic clk;
    logic clr_n;
    logic start1, start3;
    logic pix_ready;
    logic zero_mode;

    logic        busy1, done1, mem_rd1, pix_valid1, sof1, eol1, eof1;
    logic [3:0]  mem_addr1;
    logic [2:0]  mem_data1, pix_data1;
    logic [15:0] frame_cnt1;
    logic        busy3, done3, mem_rd3, pix_valid3, sof3, eol3, eof3;
    logic [3:0]  mem_addr3;
    logic [2:0]  mem_data3, pix_data3;
    logic [15:0] frame_cnt3;
`ifdef FRAME_SCANOUT_CRC_EN
    logic [15:0] frame_crc1, frame_crc3;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int idx[2];
    int done_cnt[2];
    int first_cyc[2];
    int last_cyc[2];
    bit stall[2];
    logic [5:0] held[2];

    frame_scanout #(
        .PX_WIDTH(4), .PX_HEIGHT(3), .PIX_W(3), .ADDR_W(4), .RD_LAT(1), .FIFO_DEPTH(4)
    ) u_dut1 (
        .clk(clk), .clr_n(clr_n), .start(start1), .busy(busy1), .done(done1),
        .mem_rd(mem_rd1), .mem_addr(mem_addr1), .mem_data(mem_data1),
        .pix_data(pix_data1), .pix_valid(pix_valid1), .pix_ready(pix_ready),
        .pix_sof(sof1), .pix_eol(eol1), .pix_eof(eof1), .frame_cnt(frame_cnt1)
`ifdef FRAME_SCANOUT_CRC_EN
        , .frame_crc(frame_crc1)
`endif
    );

    frame_scanout #(
        .PX_WIDTH(4), .PX_HEIGHT(3), .PIX_W(3), .ADDR_W(4), .RD_LAT(3), .FIFO_DEPTH(4)
    ) u_dut3 (
        .clk(clk), .clr_n(clr_n), .start(start3), .busy(busy3), .done(done3),
        .mem_rd(mem_rd3), .mem_addr(mem_addr3), .mem_data(mem_data3),
        .pix_data(pix_data3), .pix_valid(pix_valid3), .pix_ready(pix_ready),
        .pix_sof(sof3), .pix_eol(eol3), .pix_eof(eof3), .frame_cnt(frame_cnt3)
`ifdef FRAME_SCANOUT_CRC_EN
        , .frame_crc(frame_crc3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Framebuffer models: data = addr[2:0], delivered RD_LAT cycles after the read
    logic [2:0] p1;
    logic [2:0] p3 [3];
    always @(posedge clk) begin
        p1    <= mem_addr1[2:0];
        p3[0] <= mem_addr3[2:0];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_data1 = zero_mode ? 3'd0 : p1;
    assign mem_data3 = zero_mode ? 3'd0 : p3[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mon(input int d, input logic v, input logic r, input logic [2:0] pd,
                       input logic s, input logic l, input logic e, input logic dn);
        logic [2:0] exp_d;
        if (!clr_n) begin
            stall[d] = 1'b0;
            return;
        end
        if (stall[d]) begin
            check("hold_valid", v, 1);
            check("hold_data", {pd, s, l, e}, held[d]);
        end
        exp_d = zero_mode ? 3'd0 : 3'(idx[d]);
        if (v && r) begin
            check("pix_data", pd, exp_d);
            check("pix_flags", {s, l, e}, {idx[d] == 0, idx[d] % 4 == 3, idx[d] == 11});
            check("done_at_eof", dn, idx[d] == 11);
            if (idx[d] == 0) first_cyc[d] = cyc;
            last_cyc[d] = cyc;
            idx[d]++;
        end else if (dn) begin
            check("done_lone", dn, 0);
        end
        if (dn) done_cnt[d]++;
        stall[d] = v && !r;
        held[d]  = {pd, s, l, e};
    endtask

    always @(negedge clk) begin
        mon(0, pix_valid1, pix_ready, pix_data1, sof1, eol1, eof1, done1);
        mon(1, pix_valid3, pix_ready, pix_data3, sof3, eol3, eof3, done3);
        if (mem_rd1) check("addr_range1", mem_addr1 < 4'd12, 1);
        if (mem_rd3) check("addr_range3", mem_addr3 < 4'd12, 1);
    end

    task automatic prep();
        for (int d = 0; d < 2; d++) begin
            idx[d] = 0;
            done_cnt[d] = 0;
            first_cyc[d] = 0;
            last_cyc[d] = 0;
        end
    endtask

    task automatic pulse_start();
        start1 = 1'b1;
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic wait_both_done(input string tag);
        int t;
        t = 0;
        while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && t < 600) begin
            @(posedge clk);
            #1;
            pix_ready = pix_ready;
            t++;
        end
        check(tag, (done_cnt[0] > 0 && done_cnt[1] > 0), 1);
    endtask

    task automatic check_idle(input logic [15:0] fc);
        check("busy1", busy1, 0);
        check("busy3", busy3, 0);
        check("done1", done1, 0);
        check("done3", done3, 0);
        check("mem_rd1", mem_rd1, 0);
        check("mem_rd3", mem_rd3, 0);
        check("mem_addr1", mem_addr1, 0);
        check("mem_addr3", mem_addr3, 0);
        check("pix_valid1", pix_valid1, 0);
        check("pix_valid3", pix_valid3, 0);
        check("flags1", {sof1, eol1, eof1}, 0);
        check("flags3", {sof3, eol3, eof3}, 0);
        check("frame_cnt1", frame_cnt1, fc);
        check("frame_cnt3", frame_cnt3, fc);
    endtask

    task automatic frame_end(input bit gapless, input logic [15:0] fc);
        repeat (3) @(posedge clk);
        #1;
        check("npix1", idx[0], 12);
        check("npix3", idx[1], 12);
        check("ndone1", done_cnt[0], 1);
        check("ndone3", done_cnt[1], 1);
        if (gapless) begin
            check("gapless1", last_cyc[0] - first_cyc[0], 11);
            check("gapless3", last_cyc[1] - first_cyc[1], 11);
        end
        check_idle(fc);
    endtask

`ifdef FRAME_SCANOUT_CRC_EN
    function automatic logic [15:0] crc_model(input int nbytes, input logic [7:0] val);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int n = 0; n < nbytes; n++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ val[b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction
`endif

    initial begin
        int lat1, lat3, n1, n3, t;
        bit seen1, seen3;
        clr_n = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        pix_ready = 1'b1;
        zero_mode = 1'b0;
        prep();
        repeat (3) @(posedge clk);
        #1;
        clr_n = 1'b1;

        // Reset state
        check_idle(16'd0);
`ifdef FRAME_SCANOUT_CRC_EN
        check("crc_reset1", frame_crc1, 16'hFFFF);
        check("crc_reset3", frame_crc3, 16'hFFFF);
`endif

        // Full-rate frame, first-pixel latency RD_LAT+1
        prep();
        pulse_start();
        lat1 = 0;
        lat3 = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            if (pix_valid1 && lat1 == 0) lat1 = n;
            if (pix_valid3 && lat3 == 0) lat3 = n;
        end
        check("latency1", lat1, 2);
        check("latency3", lat3, 4);
        wait_both_done("done_a");
        frame_end(1'b1, 16'd1);

        // Random backpressure
        prep();
        pulse_start();
        t = 0;
        while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && t < 600) begin
            @(posedge clk);
            #1;
            pix_ready = 1'($urandom_range(0, 1));
            t++;
        end
        check("done_rand", (done_cnt[0] > 0 && done_cnt[1] > 0), 1);
        pix_ready = 1'b1;
        frame_end(1'b0, 16'd2);

        // Stalled sink: read credit limits issue to FIFO_DEPTH
        prep();
        pix_ready = 1'b0;
        pulse_start();
        n1 = 0;
        n3 = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_rd1) n1++;
            if (mem_rd3) n3++;
        end
        check("stall_reads1", n1, 4);
        check("stall_reads3", n3, 4);
        check("stall_valid1", pix_valid1, 1);
        check("stall_busy3", busy3, 1);
        @(posedge clk);
        #1;
        pix_ready = 1'b1;
        wait_both_done("done_stall");
        frame_end(1'b1, 16'd3);

        // Starts during SCAN and on the done cycle are ignored
        prep();
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        pulse_start();
        seen1 = 1'b0;
        seen3 = 1'b0;
        for (int k = 0; k < 200 && !(seen1 && seen3); k++) begin
            @(negedge clk);
            start1 = done1;
            start3 = done3;
            if (done1) seen1 = 1'b1;
            if (done3) seen3 = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
            start3 = 1'b0;
        end
        check("done_seen_e", seen1 && seen3, 1);
        repeat (10) @(posedge clk);
        frame_end(1'b1, 16'd4);

        // Reset at pixel 5, then a fresh frame
        prep();
        pulse_start();
        t = 0;
        while (idx[0] < 5 && t < 100) begin
            @(posedge clk);
            t++;
        end
        check("reach_px5", idx[0], 5);
        #1;
        clr_n = 1'b0;
        @(negedge clk);
        check_idle(16'd0);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        prep();
        pulse_start();
        wait_both_done("done_after_reset");
        frame_end(1'b1, 16'd1);

`ifdef FRAME_SCANOUT_CRC_EN
        // All-zero frame CRC
        zero_mode = 1'b1;
        prep();
        pulse_start();
        wait_both_done("done_crc");
        frame_end(1'b1, 16'd2);
        check("crc_zero1", frame_crc1, crc_model(12, 8'h00));
        check("crc_zero3", frame_crc3, crc_model(12, 8'h00));
        zero_mode = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
